gpio_mux_ctrl: RTL and testbench

Wishbone-configurable GPIO ownership multiplexer, parametrised in pin count and team count. Each GPIO pin has its own select field that chooses which team's out/oeb drives it, or none. Software writes shadow selects, then commits them. Pins whose owner changes are held safe (tri-stated) for a programmable blanking window, so two designs never fight over a pin during handover. Sits between the per-team design wrappers and the Caravel GPIO pads.

---
 rtl/gpio_mux_ctrl.sv | 169 ++++++++++++++++
 tb/tb_gpio_mux_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_mux_ctrl.sv
// GPIO ownership multiplexer: Wishbone-programmed per-pin team selects with a
// shadow/staged/active pipeline and a tri-state blanking window on handover.
module gpio_mux_ctrl #(
   parameter int          NUM_TEAMS    = 12,
   parameter int          NUM_PINS     = 34,
   parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
   parameter int          BLANK_CYCLES = 4
) (
   input  logic                          wb_clk_i,
   input  logic                          wb_rst_ni,
   input  logic                          wbs_stb_i,
   input  logic                          wbs_cyc_i,
   input  logic                          wbs_we_i,
   input  logic [3:0]                    wbs_sel_i,
   input  logic [31:0]                   wbs_dat_i,
   input  logic [31:0]                   wbs_adr_i,
   output logic                          wbs_ack_o,
   output logic [31:0]                   wbs_dat_o,
   input  logic [NUM_TEAMS*NUM_PINS-1:0] designs_gpio_out,
   input  logic [NUM_TEAMS*NUM_PINS-1:0] designs_gpio_oeb,
   output logic [NUM_PINS-1:0]           gpio_out,
   output logic [NUM_PINS-1:0]           gpio_oeb,
   output logic                          busy_o
);

   localparam int NUM_WORDS = (NUM_PINS + 3) / 4;
   localparam logic [5:0] CTRL_WORD = 6'h20;

   typedef enum logic [1:0] {IDLE = 2'd0, BLANK = 2'd1, APPLY = 2'd2} state_t;

   state_t                    state_r;
   logic [7:0]                cnt_r;
   logic [NUM_PINS-1:0]       blank_mask_r;
   logic [NUM_PINS-1:0][7:0]  staged_r;
   logic [NUM_PINS-1:0][7:0]  active_r;
   logic                      ack_r;
   logic [31:0]               dat_r;

   logic                      req_s;
   logic                      hit_s;
   logic [5:0]                word_s;
   logic                      wr_s;
   logic                      commit_s;
   logic [NUM_PINS-1:0]       diff_s;
   logic [NUM_PINS*8-1:0]     shadow_flat_s;
   logic [NUM_WORDS*32-1:0]   shadow_pad_s;
   logic [NUM_WORDS:0][31:0]  rd_chain_s;
   logic [31:0]               rd_s;
   logic                      unused_ok_s;

   // Out-of-range team numbers collapse to "unowned" so the output mux never
   // sees a select it cannot resolve.
   function automatic logic [7:0] clamp_sel(input logic [7:0] v);
      if (v > 8'(NUM_TEAMS)) begin
         clamp_sel = 8'd0;
      end else begin
         clamp_sel = v;
      end
   endfunction

   assign req_s       = wbs_stb_i & wbs_cyc_i & ~ack_r;
   assign hit_s       = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
   assign word_s      = wbs_adr_i[7:2];
   assign wr_s        = req_s & wbs_we_i & hit_s;
   assign commit_s    = wr_s & (word_s == CTRL_WORD) & wbs_sel_i[0] & wbs_dat_i[0];
   assign unused_ok_s = &{1'b0, wbs_adr_i[1:0]};

   for (genvar p = 0; p < NUM_PINS; p++) begin : g_pin
      localparam int         BYTE = p % 4;
      localparam logic [5:0] WORD = 6'(p / 4);
      logic [7:0]           shadow_r;
      logic [NUM_TEAMS-1:0] match_s;
      logic [NUM_TEAMS-1:0] out_vec_s;
      logic [NUM_TEAMS-1:0] oeb_vec_s;

      // Software-visible shadow select for this pin.
      always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
         if (!wb_rst_ni) begin
            shadow_r <= 8'd0;
         end else if (wr_s && (word_s == WORD) && wbs_sel_i[BYTE]) begin
            shadow_r <= clamp_sel(wbs_dat_i[8*BYTE +: 8]);
         end
      end

      for (genvar t = 0; t < NUM_TEAMS; t++) begin : g_team
         assign match_s[t]   = (active_r[p] == 8'(t + 1));
         assign out_vec_s[t] = designs_gpio_out[t*NUM_PINS + p];
         assign oeb_vec_s[t] = designs_gpio_oeb[t*NUM_PINS + p];
      end

      assign shadow_flat_s[8*p +: 8] = shadow_r;
      assign diff_s[p]               = (shadow_r != active_r[p]);
      // match_s is one-hot when owned; all-zero means unowned and forces safe.
      assign gpio_out[p] = ~blank_mask_r[p] & (|(match_s & out_vec_s));
      assign gpio_oeb[p] = blank_mask_r[p] | ~(|match_s) | (|(match_s & oeb_vec_s));
   end

   assign shadow_pad_s  = (NUM_WORDS*32)'(shadow_flat_s);
   assign rd_chain_s[0] = 32'd0;
   for (genvar k = 0; k < NUM_WORDS; k++) begin : g_rd
      assign rd_chain_s[k+1] = rd_chain_s[k] |
                               ((word_s == 6'(k)) ? shadow_pad_s[32*k +: 32] : 32'd0);
   end

   // Read data mux for the register map.
   always_comb begin
      rd_s = 32'd0;
      if (!hit_s) begin
         rd_s = 32'd0;
      end else if (word_s == CTRL_WORD) begin
         rd_s = {30'd0, (state_r != IDLE), 1'b0};
      end else begin
         rd_s = rd_chain_s[NUM_WORDS];
      end
   end

   // Single-cycle registered acknowledge with data valid only in the ack cycle.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         ack_r <= 1'b0;
         dat_r <= 32'd0;
      end else begin
         ack_r <= req_s;
         dat_r <= req_s ? rd_s : 32'd0;
      end
   end

   // Commit sequencer: stage, blank changing pins, then apply.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_r      <= IDLE;
         cnt_r        <= 8'd0;
         blank_mask_r <= '0;
         staged_r     <= '0;
         active_r     <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (commit_s) begin
                  staged_r     <= shadow_flat_s;
                  blank_mask_r <= diff_s;
                  cnt_r        <= 8'(BLANK_CYCLES - 1);
                  state_r      <= (|diff_s) ? BLANK : APPLY;
               end
            end
            BLANK: begin
               if (cnt_r == 8'd0) begin
                  state_r <= APPLY;
               end else begin
                  cnt_r <= cnt_r - 8'd1;
               end
            end
            APPLY: begin
               active_r     <= staged_r;
               blank_mask_r <= '0;
               state_r      <= IDLE;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign wbs_ack_o = ack_r;
   assign wbs_dat_o = dat_r;
   assign busy_o    = (state_r != IDLE);

endmodule

// File: tb/tb_gpio_mux_ctrl.sv
// Bench for gpio_mux_ctrl: register vector table, hand-written commit/bus
// sequences, and randomized traffic against a timeline-based reference model.
module tb_gpio_mux_ctrl;

   localparam int          NT   = 3;
   localparam int          NP   = 34;
   localparam int          BC   = 4;
   localparam int          NW   = (NP + 3) / 4;
   localparam logic [31:0] BASE = 32'h3000_0000;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             stb, cyc, we_i;
   logic [3:0]       sel_i;
   logic [31:0]      dat_i, adr_i;
   logic             ack;
   logic [31:0]      dat_o;
   logic [NT*NP-1:0] tgo, tgoe;
   logic [NP-1:0]    gpio_out, gpio_oeb;
   logic             busy;

   gpio_mux_ctrl #(.NUM_TEAMS(NT), .NUM_PINS(NP), .BASE_ADDR(BASE), .BLANK_CYCLES(BC)) dut (
      .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs_stb_i(stb), .wbs_cyc_i(cyc),
      .wbs_we_i(we_i), .wbs_sel_i(sel_i), .wbs_dat_i(dat_i), .wbs_adr_i(adr_i),
      .wbs_ack_o(ack), .wbs_dat_o(dat_o),
      .designs_gpio_out(tgo), .designs_gpio_oeb(tgoe),
      .gpio_out(gpio_out), .gpio_oeb(gpio_oeb), .busy_o(busy));

   always #5 clk = ~clk;

   int cyc_cnt = 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: shadow selects plus the most recent commit's timeline.
   logic [7:0] m_shadow [NP];
   logic [7:0] m_old    [NP];
   logic [7:0] m_staged [NP];
   bit         m_changed[NP];
   int         m_apply;

   typedef struct {
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      logic [31:0] exp;
   } vec_t;
   vec_t tbl[16];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   function automatic bit m_busy(input int n);
      return n < m_apply;
   endfunction

   task automatic model_reset();
      for (int p = 0; p < NP; p++) begin
         m_shadow[p] = 8'd0; m_old[p] = 8'd0; m_staged[p] = 8'd0; m_changed[p] = 1'b0;
      end
      m_apply = -100;
   endtask

   function automatic logic [31:0] m_read(input logic [31:0] adr, input int n);
      logic [31:0] r;
      int off;
      r = 32'd0;
      if (adr[31:8] == BASE[31:8]) begin
         off = int'({adr[7:2], 2'b00});
         if (off < NW*4) begin
            for (int b = 0; b < 4; b++)
               if (off + b < NP) r = r | (32'(m_shadow[off+b]) << (8*b));
         end else if (off == 128) begin
            r = {30'd0, m_busy(n-1), 1'b0};
         end
      end
      return r;
   endfunction

   task automatic m_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel, input int n);
      int off, v;
      bit any;
      if (adr[31:8] == BASE[31:8]) begin
         off = int'({adr[7:2], 2'b00});
         if (off < NW*4) begin
            for (int b = 0; b < 4; b++) begin
               if (off + b < NP && sel[b]) begin
                  v = int'(8'(dat >> (8*b)));
                  if (v > NT) v = 0;
                  m_shadow[off+b] = 8'(v);
               end
            end
         end else if (off == 128 && sel[0] && dat[0] && !m_busy(n-1)) begin
            any = 1'b0;
            for (int p = 0; p < NP; p++) begin
               m_old[p]     = m_staged[p];
               m_changed[p] = (m_shadow[p] != m_staged[p]);
               any          = any | m_changed[p];
               m_staged[p]  = m_shadow[p];
            end
            m_apply = n + (any ? BC + 1 : 1);
         end
      end
   endtask

   task automatic check_pins(input int n);
      logic [NP-1:0] eo, ee;
      bit bz;
      int act;
      bz = m_busy(n);
      for (int p = 0; p < NP; p++) begin
         act = bz ? int'(m_old[p]) : int'(m_staged[p]);
         if ((bz && m_changed[p]) || act == 0) begin
            eo[p] = 1'b0; ee[p] = 1'b1;
         end else begin
            eo[p] = tgo[(act-1)*NP + p]; ee[p] = tgoe[(act-1)*NP + p];
         end
      end
      chk("gpio_out", 64'(gpio_out), 64'(eo));
      chk("gpio_oeb", 64'(gpio_oeb), 64'(ee));
      chk("busy_o", 64'(busy), 64'(bz));
   endtask

   task automatic rand_teams();
      for (int i = 0; i < NT*NP; i++) begin
         tgo[i] = 1'($urandom); tgoe[i] = 1'($urandom);
      end
   endtask

   task automatic tick(input int k, input bit rnd);
      repeat (k) begin
         @(posedge clk); #1;
         check_pins(cyc_cnt);
         if (rnd) rand_teams();
      end
   endtask

   task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, output logic [31:0] rd);
      bit got;
      int n;
      got = 1'b0; rd = 32'd0;
      @(negedge clk);
      stb = 1'b1; cyc = 1'b1; we_i = we; adr_i = adr; dat_i = dat; sel_i = sel;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (ack) begin
            n = cyc_cnt; rd = dat_o; got = 1'b1;
            if (!we) chk("wb_read_data", 64'(rd), 64'(m_read(adr, n)));
            else m_write(adr, dat, sel, n);
            check_pins(n);
            break;
         end
         check_pins(cyc_cnt);
      end
      stb = 1'b0; cyc = 1'b0; we_i = 1'b0;
      if (!got) begin
         n_checks++; n_fail++;
         $display("FAIL wb_ack_timeout: got no ack, required ack within 4 cycles (adr %h)", adr);
      end else begin
         @(posedge clk); #1;
         chk("ack_single_cycle", 64'(ack), 64'(1'b0));
         chk("dat_idle_zero", 64'(dat_o), 64'(32'd0));
         check_pins(cyc_cnt);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      rst_n = 1'b0; stb = 1'b0; cyc = 1'b0; we_i = 1'b0;
      sel_i = 4'h0; dat_i = 32'd0; adr_i = 32'd0;
      rand_teams();
      model_reset();

      tbl[0]  = '{1'b1, 32'h3000_0000, 32'h0001_0203, 4'hF, 32'h0};
      tbl[1]  = '{1'b0, 32'h3000_0000, 32'h0,         4'hF, 32'h0001_0203};
      tbl[2]  = '{1'b1, 32'h3000_0000, 32'hFF05_0702, 4'h5, 32'h0};
      tbl[3]  = '{1'b0, 32'h3000_0000, 32'h0,         4'hF, 32'h0000_0202};
      tbl[4]  = '{1'b1, 32'h3000_0020, 32'h0101_0101, 4'hF, 32'h0};
      tbl[5]  = '{1'b0, 32'h3000_0020, 32'h0,         4'hF, 32'h0000_0101};
      tbl[6]  = '{1'b1, 32'h3100_0004, 32'h0101_0101, 4'hF, 32'h0};
      tbl[7]  = '{1'b0, 32'h3000_0004, 32'h0,         4'hF, 32'h0};
      tbl[8]  = '{1'b0, 32'h3100_0000, 32'h0,         4'hF, 32'h0};
      tbl[9]  = '{1'b0, 32'h3000_0084, 32'h0,         4'hF, 32'h0};
      tbl[10] = '{1'b0, 32'h3000_0024, 32'h0,         4'hF, 32'h0};
      tbl[11] = '{1'b0, 32'h3000_0080, 32'h0,         4'hF, 32'h0};
      tbl[12] = '{1'b1, 32'h3000_0004, 32'h0302_0100, 4'hF, 32'h0};
      tbl[13] = '{1'b0, 32'h3000_0004, 32'h0,         4'hF, 32'h0302_0100};
      tbl[14] = '{1'b1, 32'h3000_0007, 32'h0200_0000, 4'h8, 32'h0};
      tbl[15] = '{1'b0, 32'h3000_0005, 32'h0,         4'hF, 32'h0202_0100};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ack", 64'(ack), 64'(1'b0));
      chk("rst_dat", 64'(dat_o), 64'(32'd0));
      chk("rst_oeb_all_ones", 64'(gpio_oeb), 64'({NP{1'b1}}));
      check_pins(cyc_cnt);
      @(negedge clk); rst_n = 1'b1;

      for (int i = 0; i < 16; i++) begin
         wb_xfer(tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel, rd);
         if (!tbl[i].we) chk($sformatf("tbl_read_%0d", i), 64'(rd), 64'(tbl[i].exp));
      end

      // Commit of teams 3,2,1,0 on pins 0..3 with a known team-2 pattern
      tgo[2*NP-1:NP] = 34'h2_AAAA_AAAA;
      tgoe[2*NP-1:NP] = '0;
      wb_xfer(1'b1, BASE, 32'h0001_0203, 4'hF, rd);
      wb_xfer(1'b1, BASE + 32'h80, 32'h1, 4'h1, rd);
      chk("commit_busy_rises", 64'(busy), 64'(1'b1));
      wb_xfer(1'b0, BASE + 32'h80, 32'h0, 4'hF, rd);
      chk("ctrl_read_busy", 64'(rd), 64'(32'h2));
      tick(1, 1'b0);
      chk("apply_cycle_busy", 64'(busy), 64'(1'b1));
      chk("apply_cycle_safe", 64'(gpio_oeb[3:0]), 64'(4'hF));
      tick(1, 1'b0);
      chk("pin1_team2_out", 64'(gpio_out[1]), 64'(1'b1));
      chk("pin1_team2_oeb", 64'(gpio_oeb[1]), 64'(1'b0));
      chk("pin3_unowned", 64'(gpio_oeb[3]), 64'(1'b1));
      chk("busy_done", 64'(busy), 64'(1'b0));

      // Selective blanking: only pin 1 changes owner
      rand_teams();
      wb_xfer(1'b1, BASE, 32'h0000_0201, 4'hF, rd);
      wb_xfer(1'b1, BASE + 32'h80, 32'h1, 4'h1, rd);
      tick(5, 1'b1);
      wb_xfer(1'b1, BASE, 32'h0000_0301, 4'hF, rd);
      wb_xfer(1'b1, BASE + 32'h80, 32'h1, 4'h1, rd);
      chk("sel_pin1_safe", 64'(gpio_oeb[1]), 64'(1'b1));
      chk("sel_pin0_team1", 64'(gpio_oeb[0]), 64'(tgoe[0]));
      tick(3, 1'b0);
      chk("sel_pin1_safe_apply", 64'(gpio_oeb[1]), 64'(1'b1));
      tick(1, 1'b0);
      chk("sel_pin1_team3_out", 64'(gpio_out[1]), 64'(tgo[2*NP+1]));
      chk("sel_pin1_team3_oeb", 64'(gpio_oeb[1]), 64'(tgoe[2*NP+1]));

      // Commit and shadow writes while busy
      wb_xfer(1'b1, BASE, 32'h0000_0102, 4'hF, rd);
      wb_xfer(1'b1, BASE + 32'h80, 32'h1, 4'h1, rd);
      wb_xfer(1'b1, BASE + 32'h4, 32'h0101_0101, 4'hF, rd);
      wb_xfer(1'b1, BASE + 32'h80, 32'h1, 4'h1, rd);
      chk("busy_drops_on_time", 64'(busy), 64'(1'b0));
      wb_xfer(1'b0, BASE + 32'h4, 32'h0, 4'hF, rd);
      chk("shadow_kept_while_busy", 64'(rd), 64'(32'h0101_0101));
      chk("pin4_not_applied", 64'(gpio_oeb[4]), 64'(1'b1));
      wb_xfer(1'b1, BASE + 32'h80, 32'h1, 4'h1, rd);
      tick(6, 1'b1);
      chk("pin4_applied_next", 64'(gpio_oeb[4]), 64'(tgoe[4]));

      // Reset in the middle of BLANK
      wb_xfer(1'b1, BASE, 32'h0000_0303, 4'hF, rd);
      wb_xfer(1'b1, BASE + 32'h80, 32'h1, 4'h1, rd);
      tick(1, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("midrst_oeb", 64'(gpio_oeb), 64'({NP{1'b1}}));
      chk("midrst_out", 64'(gpio_out), 64'(0));
      chk("midrst_busy", 64'(busy), 64'(1'b0));
      @(negedge clk); rst_n = 1'b1;
      wb_xfer(1'b0, BASE, 32'h0, 4'hF, rd);
      chk("midrst_sel0", 64'(rd), 64'(32'h0));
      tick(2, 1'b1);

      // Back-to-back strobe: ack every other cycle
      @(negedge clk);
      stb = 1'b1; cyc = 1'b1; we_i = 1'b0; adr_i = BASE + 32'h80; sel_i = 4'hF;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         chk("b2b_ack", 64'(ack), 64'((i % 2) == 0));
      end
      stb = 1'b0; cyc = 1'b0;
      @(posedge clk); #1;

      // Strobe without cycle: no ack and no write
      @(negedge clk);
      stb = 1'b1; cyc = 1'b0; we_i = 1'b1; adr_i = BASE; dat_i = 32'h0303_0303; sel_i = 4'hF;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         chk("no_cyc_no_ack", 64'(ack), 64'(1'b0));
      end
      stb = 1'b0; we_i = 1'b0;
      wb_xfer(1'b0, BASE, 32'h0, 4'hF, rd);

      // Randomized traffic against the model
      for (int it = 0; it < 250; it++) begin
         int r;
         logic [31:0] a, d;
         r = $urandom_range(0, 9);
         if (r <= 3) begin
            a = BASE + 32'($urandom_range(0, 9) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = a ^ 32'h0100_0000;
            d = {8'($urandom_range(0, 5)), 8'($urandom_range(0, 5)),
                 8'($urandom_range(0, 5)), 8'($urandom_range(0, 5))};
            wb_xfer(1'b1, a, d, 4'($urandom), rd);
         end else if (r == 4) begin
            wb_xfer(1'b1, BASE + 32'h80, 32'h1, 4'h1, rd);
         end else if (r <= 6) begin
            a = ($urandom_range(0, 3) == 0) ? BASE + 32'h80 : BASE + 32'($urandom_range(0, 10) * 4);
            wb_xfer(1'b0, a, 32'h0, 4'hF, rd);
         end else begin
            tick($urandom_range(1, 6), 1'b1);
         end
      end
      tick(8, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
